// File: rtl/ffd_sync_bank_pkg.sv
// Shared constants and helpers for the ffd_sync_bank input conditioner.
// RESET_VAL convention: a single bit replicated into every per-channel flop on reset.
package ffd_sync_bank_pkg;

  localparam int   DEF_WIDTH     = 8;
  localparam int   DEF_STAGES    = 2;
  localparam int   DEF_DB_CYCLES = 4;
  localparam logic DEF_RESET_VAL = 1'b0;

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
  } chan_out_t;

  // Counter must hold 0..D; never narrower than one bit.
  function automatic int cnt_width(input int d);
    if (d < 1) return 1;
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/ffd_sync_bank_if.sv
// Raw inputs, capture enable and conditioned outputs of the ffd_sync_bank.
interface ffd_sync_bank_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] datos;
  logic             enable;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output datos,
    output enable,
    input  q_out,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  datos,
    input  enable,
    output q_out,
    output rise,
    output fall,
    output changed
  );

endinterface

// File: rtl/ffd_sync_bit.sv
// One channel: synchronizer chain, optional debounce filter, enable-gated hold
// register and registered rise/fall pulse generation.
module ffd_sync_bit
  import ffd_sync_bank_pkg::*;
#(
  parameter int   STAGES    = DEF_STAGES,
  parameter int   DB_CYCLES = DEF_DB_CYCLES,
  parameter logic RESET_VAL = DEF_RESET_VAL
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      din,
  input  logic      enable,
  output chan_out_t chan
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              stable_q, stable_d;
  logic              q_q, q_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              s;

  // Sync chain shifts every cycle regardless of enable.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  assign s = sync_q[STAGES-1];

  generate
    if (DB_CYCLES == 0) begin : g_no_db
      always_comb begin
        stable_d = s;
      end
    end else begin : g_db
      localparam int CW = cnt_width(DB_CYCLES);
      logic [CW-1:0] cnt_q, cnt_d;

      // Any cycle where s matches stable restarts the persistence count.
      always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (s != stable_q) begin
          if (cnt_q == CW'(DB_CYCLES - 1)) begin
            stable_d = s;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_comb begin
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (enable) begin
      q_d    = stable_q;
      rise_d = stable_q & ~q_q;
      fall_d = ~stable_q & q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {STAGES{RESET_VAL}};
      stable_q <= RESET_VAL;
      q_q      <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign chan.q    = q_q;
  assign chan.rise = rise_q;
  assign chan.fall = fall_q;

endmodule

// File: rtl/ffd_sync_bank.sv
// WIDTH independent conditioned channels; changed flags any edge pulse this cycle.
module ffd_sync_bank
  import ffd_sync_bank_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter int   STAGES    = DEF_STAGES,
  parameter int   DB_CYCLES = DEF_DB_CYCLES,
  parameter logic RESET_VAL = DEF_RESET_VAL
) (
  input  logic             clk,
  input  logic             reset,
  ffd_sync_bank_if.slave   bus
);

  chan_out_t        ch [WIDTH];
  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      ffd_sync_bit #(
        .STAGES    (STAGES),
        .DB_CYCLES (DB_CYCLES),
        .RESET_VAL (RESET_VAL)
      ) u_bit (
        .clk    (clk),
        .reset  (reset),
        .din    (bus.datos[i]),
        .enable (bus.enable),
        .chan   (ch[i])
      );

      assign q_vec[i]    = ch[i].q;
      assign rise_vec[i] = ch[i].rise;
      assign fall_vec[i] = ch[i].fall;
    end
  endgenerate

  assign bus.q_out   = q_vec;
  assign bus.rise    = rise_vec;
  assign bus.fall    = fall_vec;
  assign bus.changed = |(rise_vec | fall_vec);

endmodule

// File: tb/tb_ffd_sync_bank.sv
// Directed bench for ffd_sync_bank: default build plus a STAGES=3, DB_CYCLES=0 build.
module tb_ffd_sync_bank;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ffd_sync_bank_if #(.WIDTH(8)) bif ();
  ffd_sync_bank_if #(.WIDTH(4)) bif2 ();

  ffd_sync_bank #(.WIDTH(8), .STAGES(2), .DB_CYCLES(4), .RESET_VAL(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  ffd_sync_bank #(.WIDTH(4), .STAGES(3), .DB_CYCLES(0), .RESET_VAL(1'b0)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bif2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bif.datos   = 8'h00;
    bif.enable  = 1'b1;
    bif2.datos  = 4'h0;
    bif2.enable = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bif.datos   = 8'hFF;
    bif.enable  = 1'b1;
    bif2.datos  = 4'hF;
    bif2.enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) reset = 1'b0;
      tick();
      n_cmp++;
      if (bif.q_out !== 8'h00 || bif.rise !== 8'h00 || bif.fall !== 8'h00 || bif.changed !== 1'b0) begin
        n_bad++;
        $display("FAIL reset c=%0d: q=%h rise=%h fall=%h chg=%b, want 00/00/00/0",
                 c, bif.q_out, bif.rise, bif.fall, bif.changed);
      end
      n_cmp++;
      if (bif2.q_out !== 4'h0 || bif2.rise !== 4'h0 || bif2.changed !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_d0 c=%0d: q=%h rise=%h chg=%b, want 0/0/0",
                 c, bif2.q_out, bif2.rise, bif2.changed);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [7:0] exp_q, exp_r;
    do_reset();
    bif.datos = 8'h01;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_q = (e >= 7) ? 8'h01 : 8'h00;
      exp_r = (e == 7) ? 8'h01 : 8'h00;
      n_cmp++;
      if (bif.q_out !== exp_q || bif.rise !== exp_r || bif.fall !== 8'h00) begin
        n_bad++;
        $display("FAIL clean_step edge %0d: q=%h rise=%h fall=%h, want q=%h rise=%h fall=00",
                 e, bif.q_out, bif.rise, bif.fall, exp_q, exp_r);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] exp_q, exp_r, exp_f;
    do_reset();
    bif.datos = 8'h08;
    repeat (3) tick();
    bif.datos = 8'h00;
    for (int e = 4; e <= 12; e++) begin
      tick();
      n_cmp++;
      if (bif.q_out !== 8'h00 || bif.rise !== 8'h00 || bif.changed !== 1'b0) begin
        n_bad++;
        $display("FAIL glitch3 edge %0d: q=%h rise=%h chg=%b, want 00/00/0",
                 e, bif.q_out, bif.rise, bif.changed);
      end
    end
    // Four-cycle level is accepted; it then falls back after the same filter.
    bif.datos = 8'h08;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 4) bif.datos = 8'h00;
      exp_q = (e >= 7 && e <= 10) ? 8'h08 : 8'h00;
      exp_r = (e == 7) ? 8'h08 : 8'h00;
      exp_f = (e == 11) ? 8'h08 : 8'h00;
      n_cmp++;
      if (bif.q_out !== exp_q || bif.rise !== exp_r || bif.fall !== exp_f) begin
        n_bad++;
        $display("FAIL glitch4 edge %0d: q=%h rise=%h fall=%h, want q=%h rise=%h fall=%h",
                 e, bif.q_out, bif.rise, bif.fall, exp_q, exp_r, exp_f);
      end
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    bif.enable = 1'b0;
    bif.datos  = 8'h20;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_cmp++;
      if (bif.q_out !== 8'h00 || bif.rise !== 8'h00) begin
        n_bad++;
        $display("FAIL enable_hold edge %0d: q=%h rise=%h, want 00/00", e, bif.q_out, bif.rise);
      end
    end
    bif.enable = 1'b1;
    tick();
    n_cmp++;
    if (bif.q_out !== 8'h20 || bif.rise !== 8'h20 || bif.changed !== 1'b1) begin
      n_bad++;
      $display("FAIL enable_rise: q=%h rise=%h chg=%b, want 20/20/1", bif.q_out, bif.rise, bif.changed);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_cmp++;
      if (bif.q_out !== 8'h20 || bif.rise !== 8'h00 || bif.changed !== 1'b0) begin
        n_bad++;
        $display("FAIL enable_once +%0d: q=%h rise=%h chg=%b, want 20/00/0",
                 e, bif.q_out, bif.rise, bif.changed);
      end
    end
  endtask

  task automatic test_multi_fall();
    logic [7:0] exp_q, exp_r, exp_f;
    logic       exp_c;
    do_reset();
    bif.datos = 8'hA5;
    repeat (10) tick();
    n_cmp++;
    if (bif.q_out !== 8'hA5) begin
      n_bad++;
      $display("FAIL multi_settle: q=%h, want a5", bif.q_out);
    end
    bif.datos = 8'h5A;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_q = (e >= 7) ? 8'h5A : 8'hA5;
      exp_r = (e == 7) ? 8'h5A : 8'h00;
      exp_f = (e == 7) ? 8'hA5 : 8'h00;
      exp_c = (e == 7);
      n_cmp++;
      if (bif.q_out !== exp_q || bif.rise !== exp_r || bif.fall !== exp_f || bif.changed !== exp_c) begin
        n_bad++;
        $display("FAIL multi edge %0d: q=%h rise=%h fall=%h chg=%b, want %h/%h/%h/%b",
                 e, bif.q_out, bif.rise, bif.fall, bif.changed, exp_q, exp_r, exp_f, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [7:0] exp_q, exp_r;
    do_reset();
    bif.datos = 8'h02;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (bif.q_out !== 8'h00 || bif.rise !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid: q=%h rise=%h, want 00/00", bif.q_out, bif.rise);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_q = (e >= 7) ? 8'h02 : 8'h00;
      exp_r = (e == 7) ? 8'h02 : 8'h00;
      n_cmp++;
      if (bif.q_out !== exp_q || bif.rise !== exp_r) begin
        n_bad++;
        $display("FAIL reset_mid edge %0d: q=%h rise=%h, want q=%h rise=%h",
                 e, bif.q_out, bif.rise, exp_q, exp_r);
      end
    end
  endtask

  task automatic test_no_debounce();
    logic [3:0] exp_q, exp_r, exp_f;
    do_reset();
    bif2.datos = 4'h1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_q = (e >= 5) ? 4'h1 : 4'h0;
      exp_r = (e == 5) ? 4'h1 : 4'h0;
      n_cmp++;
      if (bif2.q_out !== exp_q || bif2.rise !== exp_r) begin
        n_bad++;
        $display("FAIL d0_rise edge %0d: q=%h rise=%h, want q=%h rise=%h",
                 e, bif2.q_out, bif2.rise, exp_q, exp_r);
      end
    end
    bif2.datos = 4'h0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_q = (e >= 5) ? 4'h0 : 4'h1;
      exp_f = (e == 5) ? 4'h1 : 4'h0;
      n_cmp++;
      if (bif2.q_out !== exp_q || bif2.fall !== exp_f || bif2.changed !== (e == 5)) begin
        n_bad++;
        $display("FAIL d0_fall edge %0d: q=%h fall=%h chg=%b, want q=%h fall=%h",
                 e, bif2.q_out, bif2.fall, bif2.changed, exp_q, exp_f);
      end
    end
  endtask

  initial begin
    bif.datos   = 8'h00;
    bif.enable  = 1'b0;
    bif2.datos  = 4'h0;
    bif2.enable = 1'b0;
    #2;
    test_reset();
    test_clean_step();
    test_glitch();
    test_enable_hold();
    test_multi_fall();
    test_reset_mid_debounce();
    test_no_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
